// File: rtl/fpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// fpu_seq_pkg
// Shared types and constants for the FP32 op sequencer and any other issue
// logic that needs to classify RISC-V OP-FP instructions.
//   fpu_op_e     : decoded operation class
//   seq_state_e  : sequencer FSM states
//   OPFP_OPCODE, FUNCT7_* : instruction encodings recognised by the decoder
//   DIV_DONE_FLAG: divider status value meaning "result valid"
//   ERR_*        : response error codes
// -----------------------------------------------------------------------------
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_ILL
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIV_WAIT,
        RESP
    } seq_state_e;

    localparam logic [6:0] OPFP_OPCODE  = 7'b1010011;
    localparam logic [6:0] FUNCT7_ADD   = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB   = 7'b0000100;
    localparam logic [6:0] FUNCT7_MUL   = 7'b0001000;
    localparam logic [6:0] FUNCT7_DIV   = 7'b0001100;

    localparam logic [5:0] DIV_DONE_FLAG = 6'd15;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILL     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/fpu_op_decode.sv
// -----------------------------------------------------------------------------
// fpu_op_decode
// Purely combinational OP-FP classifier. Anything that is not the OP-FP major
// opcode with one of the four supported funct7 codes is reported as OP_ILL.
// Ports:
//   opcode_i : instruction opcode
//   funct7_i : instruction funct7
//   op_o     : decoded operation class
// -----------------------------------------------------------------------------
module fpu_op_decode
    import fpu_seq_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    output fpu_op_e    op_o
);

    always_comb begin
        op_o = OP_ILL;
        if (opcode_i == OPFP_OPCODE) begin
            case (funct7_i)
                FUNCT7_ADD: op_o = OP_ADD;
                FUNCT7_SUB: op_o = OP_SUB;
                FUNCT7_MUL: op_o = OP_MUL;
                FUNCT7_DIV: op_o = OP_DIV;
                default:    op_o = OP_ILL;
            endcase
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_op_sequencer
// Single-outstanding issue controller for the FP32 multiplier, adder/subtractor
// and SRT divider. Accepts one request, holds its operands, enables exactly one
// unit, waits for its fixed latency (or the divider's done flag / timeout) and
// returns the captured result with the request tag.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_*_i / req_ready_o        : request channel (valid/ready)
//   op_a_o, op_b_o               : registered operands shared by all units
//   mul_en_o, add_en_o, div_en_o : per-unit enables (at most one high)
//   sub_sel_o                    : adder mode, 1 = subtract
//   mul/add/div_result_i         : unit results
//   div_flag_i                   : divider status, DIV_DONE_FLAG = result valid
//   rsp_*_o / rsp_ready_i        : response channel (valid/ready)
// -----------------------------------------------------------------------------
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int MUL_LAT     = 2,
    parameter int ADD_LAT     = 3,
    parameter int DIV_TIMEOUT = 64,
    parameter int TAG_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [6:0]       req_opcode_i,
    input  logic [6:0]       req_funct7_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic             mul_en_o,
    output logic             add_en_o,
    output logic             sub_sel_o,
    output logic             div_en_o,
    input  logic [31:0]      mul_result_i,
    input  logic [31:0]      add_result_i,
    input  logic [31:0]      div_result_i,
    input  logic [5:0]       div_flag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [1:0]       rsp_err_o
);

    if (MUL_LAT < 1 || ADD_LAT < 1 || DIV_TIMEOUT < 1 || TAG_W < 1) begin : g_param_check
        $error("fpu_op_sequencer: MUL_LAT, ADD_LAT, DIV_TIMEOUT and TAG_W must all be >= 1");
    end

    // One counter serves both the down-count in EXEC and the up-count in DIV_WAIT.
    localparam int LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_MAX = (LAT_MAX > DIV_TIMEOUT) ? LAT_MAX : DIV_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e        state_q, state_d;
    fpu_op_e           op_q, op_d;
    fpu_op_e           dec_op;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    fpu_op_decode u_decode (
        .opcode_i (req_opcode_i),
        .funct7_i (req_funct7_i),
        .op_o     (dec_op)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= OP_ILL;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= ERR_OK;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                // req_ready is high exactly in IDLE, so valid alone is the handshake.
                if (req_valid_i) begin
                    op_d      = dec_op;
                    op_a_d    = req_a_i;
                    op_b_d    = req_b_i;
                    rsp_tag_d = req_tag_i;
                    case (dec_op)
                        OP_ADD, OP_SUB: begin
                            state_d = EXEC;
                            cnt_d   = CNT_W'(ADD_LAT - 1);
                        end
                        OP_MUL: begin
                            state_d = EXEC;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                        end
                        OP_DIV: begin
                            state_d = DIV_WAIT;
                            cnt_d   = '0;
                        end
                        default: begin
                            state_d      = RESP;
                            rsp_result_d = '0;
                            rsp_err_d    = ERR_ILL;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    rsp_err_d    = ERR_OK;
                    rsp_result_d = (op_q == OP_MUL) ? mul_result_i : add_result_i;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_WAIT: begin
                // Flag is tested first so a completion on the last allowed
                // cycle is still reported as a good result.
                if (div_flag_i == DIV_DONE_FLAG) begin
                    state_d      = RESP;
                    rsp_err_d    = ERR_OK;
                    rsp_result_d = div_result_i;
                end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                    state_d      = RESP;
                    rsp_err_d    = ERR_TIMEOUT;
                    rsp_result_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        req_ready_o = (state_q == IDLE);
        mul_en_o    = (state_q == EXEC) && (op_q == OP_MUL);
        add_en_o    = (state_q == EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB));
        sub_sel_o   = (state_q == EXEC) && (op_q == OP_SUB);
        div_en_o    = (state_q == DIV_WAIT);
        rsp_valid_o = (state_q == RESP);
    end

    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_op_sequencer
// Directed cases followed by a randomized stream. Unit models emulate the
// pipelined FP units; a transaction-level model predicts every output cycle.
// -----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

    localparam int MUL_LAT     = 2;
    localparam int ADD_LAT     = 3;
    localparam int DIV_TIMEOUT = 64;
    localparam int TAG_W       = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_opcode = '0;
    logic [6:0]  req_funct7 = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic [31:0] op_a, op_b;
    logic        mul_en, add_en, sub_sel, div_en;
    logic [31:0] mul_result, add_result, div_result;
    logic [5:0]  div_flag;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_err;

    always #5 clk = ~clk;

    fpu_op_sequencer #(
        .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .DIV_TIMEOUT(DIV_TIMEOUT), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_opcode_i(req_opcode), .req_funct7_i(req_funct7),
        .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
        .op_a_o(op_a), .op_b_o(op_b),
        .mul_en_o(mul_en), .add_en_o(add_en), .sub_sel_o(sub_sel), .div_en_o(div_en),
        .mul_result_i(mul_result), .add_result_i(add_result), .div_result_i(div_result),
        .div_flag_i(div_flag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- unit behaviour (stand-ins for the real FP units) -------
    function automatic logic [31:0] add_f(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction
    function automatic logic [31:0] sub_f(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction
    function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a * b;
    endfunction
    function automatic logic [31:0] div_f(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h3F00_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    // 0 add, 1 sub, 2 mul, 3 div, 4 illegal
    function automatic int op_class(input logic [6:0] opc, input logic [6:0] f7);
        if (opc != 7'h53) return 4;
        if (f7 == 7'h00) return 0;
        if (f7 == 7'h04) return 1;
        if (f7 == 7'h08) return 2;
        if (f7 == 7'h0C) return 3;
        return 4;
    endfunction

    // Consecutive enabled cycles already completed by each unit.
    int mul_run = 0, add_run = 0, div_run = 0;
    always @(posedge clk) begin
        mul_run <= (mul_en && !rst) ? mul_run + 1 : 0;
        add_run <= (add_en && !rst) ? add_run + 1 : 0;
        div_run <= (div_en && !rst) ? div_run + 1 : 0;
    end

    // Bench model state
    bit          m_busy = 0;
    bit          m_post_rst = 1;
    int          m_cls = 4, m_e = 0, m_lat = 0, m_dly = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]  m_err = '0;
    logic [3:0]  m_tag = '0;
    int          m_done = 0;
    int          iss_dly = 0;
    logic [3:0]  tag_q[$];

    // Results are only valid on the last cycle of each unit's latency window.
    always_comb begin
        mul_result = 32'hDEAD_0001;
        add_result = 32'hDEAD_0002;
        div_result = 32'hDEAD_0003;
        div_flag   = 6'd3;
        if (mul_en && mul_run == MUL_LAT - 1) mul_result = mul_f(op_a, op_b);
        if (add_en && add_run == ADD_LAT - 1)
            add_result = sub_sel ? sub_f(op_a, op_b) : add_f(op_a, op_b);
        if (div_en && m_dly != 0 && div_run == m_dly - 1) begin
            div_flag   = 6'd15;
            div_result = div_f(op_a, op_b);
        end
    end

    // Stats pinned by directed checks
    int          meas = 0, last_lat = 0, en_cyc = 0, last_en_cyc = 0;
    bit          seen = 0, saw_sub = 0;
    logic [31:0] last_res = '0;
    logic [1:0]  last_err = '0;
    logic [3:0]  last_tag = '0;

    // ---------------- compare + model step, once per cycle -------------------
    always @(negedge clk) begin
        bit en_exp, rv_exp;
        en_exp = m_busy && (m_e <= m_lat);
        rv_exp = m_busy && (m_e > m_lat);
        chk("req_ready", req_ready, !m_busy);
        chk("mul_en", mul_en, en_exp && m_cls == 2);
        chk("add_en", add_en, en_exp && (m_cls == 0 || m_cls == 1));
        chk("div_en", div_en, en_exp && m_cls == 3);
        chk("one_enable", (int'(mul_en) + int'(add_en) + int'(div_en)) <= 1, 1);
        if (en_exp && m_cls < 2) chk("sub_sel", sub_sel, m_cls == 1);
        chk("rsp_valid", rsp_valid, rv_exp);
        chk("op_a", op_a, m_a);
        chk("op_b", op_b, m_b);
        if (rv_exp) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_tag", rsp_tag, m_tag);
            chk("rsp_err", rsp_err, m_err);
        end
        if (m_post_rst) begin
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_tag", rsp_tag, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_sub_sel", sub_sel, 0);
        end

        if (m_busy) begin
            if (mul_en || add_en || div_en) en_cyc++;
            if (sub_sel) saw_sub = 1;
            if (!seen) begin
                meas++;
                if (rsp_valid) begin seen = 1; last_lat = meas; end
            end
        end

        // Advance the model across the coming rising edge.
        m_post_rst = 0;
        if (rst) begin
            m_busy = 0; m_a = '0; m_b = '0; m_post_rst = 1;
            tag_q.delete();
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_e = 1;
                m_cls = op_class(req_opcode, req_funct7);
                m_a = req_a; m_b = req_b; m_tag = req_tag; m_dly = iss_dly;
                meas = 0; seen = 0; en_cyc = 0; saw_sub = 0;
                case (m_cls)
                    0: begin m_lat = ADD_LAT; m_res = add_f(req_a, req_b); m_err = 2'b00; end
                    1: begin m_lat = ADD_LAT; m_res = sub_f(req_a, req_b); m_err = 2'b00; end
                    2: begin m_lat = MUL_LAT; m_res = mul_f(req_a, req_b); m_err = 2'b00; end
                    3: begin
                        if (iss_dly >= 1 && iss_dly <= DIV_TIMEOUT) begin
                            m_lat = iss_dly; m_res = div_f(req_a, req_b); m_err = 2'b00;
                        end else begin
                            m_lat = DIV_TIMEOUT; m_res = '0; m_err = 2'b10;
                        end
                    end
                    default: begin m_lat = 0; m_res = '0; m_err = 2'b01; end
                endcase
            end
        end else if (m_e > m_lat && rsp_ready) begin
            m_busy = 0;
            m_done++;
            last_res = rsp_result; last_err = rsp_err; last_tag = rsp_tag;
            last_en_cyc = en_cyc;
            if (tag_q.size() == 0) chk("tag_order_empty", {28'd0, rsp_tag}, 32'hFFFF_FFFF);
            else chk("tag_order", rsp_tag, tag_q.pop_front());
        end else begin
            m_e++;
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input int dly);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_opcode = opc; req_funct7 = f7; req_a = a; req_b = b; req_tag = tag;
        iss_dly = dly; req_valid = 1'b1;
        tag_q.push_back(tag);
        do begin @(negedge clk); n++; end while (!req_ready && n < 300);
        if (!req_ready) chk("issue_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (m_done < target && n < budget) begin @(negedge clk); n++; end
        chk("response_arrived", m_done, target);
    endtask

    bit stream_done = 0;

    initial begin
        int done_t;
        done_t = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ADD
        issue(7'h53, 7'h00, 32'h3F80_0000, 32'h4000_0000, 4'h1, 0);
        done_t++; wait_done(done_t, 50);
        chk("add_result", last_res, 32'h4040_0000);
        chk("add_err", last_err, 0);
        chk("add_tag", last_tag, 1);
        chk("add_latency", last_lat, 4);
        chk("add_en_cycles", last_en_cyc, 3);

        // MUL with response back-pressure
        rsp_ready = 1'b0;
        issue(7'h53, 7'h08, 32'h4000_0000, 32'h4040_0000, 4'h2, 0);
        repeat (7) @(posedge clk);
        #1 rsp_ready = 1'b1;
        done_t++; wait_done(done_t, 50);
        chk("mul_result", last_res, 32'h40C0_0000);
        chk("mul_err", last_err, 0);
        chk("mul_latency", last_lat, 3);
        chk("mul_en_cycles", last_en_cyc, 2);

        // DIV, flag after 20 cycles
        issue(7'h53, 7'h0C, 32'h3F80_0000, 32'h4000_0000, 4'h3, 20);
        done_t++; wait_done(done_t, 100);
        chk("div_result", last_res, 32'h3F00_0000);
        chk("div_err", last_err, 0);
        chk("div_latency", last_lat, 21);

        // DIV, never completes
        issue(7'h53, 7'h0C, 32'h3F80_0000, 32'h4000_0000, 4'h4, 0);
        done_t++; wait_done(done_t, 200);
        chk("div_to_result", last_res, 0);
        chk("div_to_err", last_err, 2);
        chk("div_to_latency", last_lat, 65);
        chk("div_to_en_cycles", last_en_cyc, 64);

        // DIV, flag on the timeout cycle
        issue(7'h53, 7'h0C, 32'h3F80_0000, 32'h4000_0000, 4'h5, 64);
        done_t++; wait_done(done_t, 200);
        chk("div_edge_result", last_res, 32'h3F00_0000);
        chk("div_edge_err", last_err, 0);

        // Illegal funct7, then illegal opcode
        issue(7'h53, 7'h7F, 32'h1234_5678, 32'h9ABC_DEF0, 4'h6, 0);
        done_t++; wait_done(done_t, 50);
        chk("ill_f7_err", last_err, 1);
        chk("ill_f7_result", last_res, 0);
        chk("ill_f7_latency", last_lat, 1);
        chk("ill_f7_en_cycles", last_en_cyc, 0);
        issue(7'h33, 7'h00, 32'h1111_1111, 32'h2222_2222, 4'h7, 0);
        done_t++; wait_done(done_t, 50);
        chk("ill_opc_err", last_err, 1);
        chk("ill_opc_result", last_res, 0);
        chk("ill_opc_en_cycles", last_en_cyc, 0);

        // Reset in the middle of DIV_WAIT
        issue(7'h53, 7'h0C, 32'hAAAA_0000, 32'h5555_0000, 4'h8, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_div_en", div_en, 0);
        chk("rst_op_a", op_a, 0);

        // SUB afterwards
        issue(7'h53, 7'h04, 32'h4040_0000, 32'h3F80_0000, 4'h9, 0);
        done_t++; wait_done(done_t, 50);
        chk("sub_result", last_res, 32'h00C0_0000);
        chk("sub_saw_sub_sel", saw_sub, 1);
        chk("sub_latency", last_lat, 4);

        // Randomized stream
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int r, d;
                    logic [6:0] opc, f7;
                    r   = $urandom_range(0, 9);
                    f7  = (r < 2) ? 7'h00 : (r < 4) ? 7'h04 : (r < 6) ? 7'h08 :
                          (r < 8) ? 7'h0C : 7'($urandom);
                    opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h53;
                    if ($urandom_range(0, 5) == 0) d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(60, 70);
                    else d = $urandom_range(1, 20);
                    issue(opc, f7, $urandom, $urandom, 4'(i), d);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
                end
                wait_done(done_t + 200, 40000);
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 9) < 7);
                end
                rsp_ready = 1'b1;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
